// File: rtl/alu_sequencer.sv
// Shared integer ALU sequencer: one-cycle logic/arith ops, bit-serial shifts.
// Valid/ready on both the issue side and the writeback side.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8
  } alu_ops_t;
endpackage

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  alu_ops_t        sh_op;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_shift;
  logic            is_illegal;
  logic            slt;
  logic [XLEN-1:0] acc_next;

  assign shamt = req_b[SHW-1:0];
  assign slt   = $signed(req_a) < $signed(req_b);

  assign req_ready = !flush &&
    (state == IDLE || (state == DONE && rsp_ready));
  assign accept = req_valid && req_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    alu_res    = '0;
    is_shift   = 1'b0;
    is_illegal = 1'b0;
    case (req_op)
      OP_ADD: alu_res = req_a + req_b;
      OP_SUB: alu_res = req_a - req_b;
      OP_AND: alu_res = req_a & req_b;
      OP_OR:  alu_res = req_a | req_b;
      OP_XOR: alu_res = req_a ^ req_b;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, slt};
      OP_SLL, OP_SRL, OP_SRA: begin
        // shamt==0 completes immediately with a
        alu_res  = req_a;
        is_shift = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    acc_next = acc;
    case (sh_op)
      OP_SLL:  acc_next = {acc[XLEN-2:0], 1'b0};
      OP_SRL:  acc_next = {1'b0, acc[XLEN-1:1]};
      default: acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh_op       <= OP_SLL;
      acc         <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else if (accept) begin
      if (is_shift && shamt != '0) begin
        state     <= SHIFT;
        sh_op     <= alu_ops_t'(req_op);
        acc       <= req_a;
        cnt       <= shamt;
        rsp_valid <= 1'b0;
      end else begin
        state       <= DONE;
        rsp_valid   <= 1'b1;
        rsp_result  <= alu_res;
        rsp_zero    <= (alu_res == '0);
        rsp_illegal <= is_illegal;
      end
    end else begin
      case (state)
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            rsp_result  <= acc_next;
            rsp_zero    <= (acc_next == '0);
            rsp_illegal <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a transaction-level reference model
// and a per-cycle compare process.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, output bit ill);
    int sh;
    sh  = int'(b % 32);
    ill = 1'b0;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return $signed(a) >>> sh;
      default: begin
        ill = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction

  // model: an op either waits m_left edges or is presented as a response
  bit          m_pend, m_valid, m_ill;
  int          m_left;
  logic [31:0] m_res;

  function automatic bit m_ready();
    return !flush && !m_pend && (!m_valid || rsp_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_valid = 0; m_ill = 0; m_left = 0; m_res = '0;
    end else if (flush) begin
      m_pend = 0; m_valid = 0;
    end else if (req_valid && m_ready()) begin
      bit il;
      int n;
      m_res = ref_alu(req_op, req_a, req_b, il);
      m_ill = il;
      n = int'(req_b % 32);
      if (req_op inside {4'd6, 4'd7, 4'd8} && n != 0) begin
        m_pend = 1; m_left = n; m_valid = 0;
      end else begin
        m_valid = 1;
      end
    end else if (m_pend) begin
      m_left--;
      if (m_left == 0) begin
        m_pend = 0; m_valid = 1;
      end
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_pend || m_valid));
      if (m_valid) begin
        chk("model_result", rsp_result, m_res);
        chk("model_zero", 32'(rsp_zero), 32'(m_res == 0));
        chk("model_illegal", 32'(rsp_illegal), 32'(m_ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] b);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
  endtask

  // issue from IDLE, scramble inputs after accept, measure latency
  task automatic run_op(input string nm, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
      input bit ill, input int lat);
    int n;
    rsp_ready = 1'b1;
    drive(op, a, b);
    step();
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 100);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_result"}, rsp_result, exp);
    chk({nm, "_zero"}, 32'(rsp_zero), 32'(exp == 0));
    chk({nm, "_illegal"}, 32'(rsp_illegal), 32'(ill));
    step();
  endtask

  logic [31:0] stream_exp [5];
  bit seen;

  initial begin
    stream_exp[0] = 32'h0000_F000;
    stream_exp[1] = 32'h0000_0100;
    stream_exp[2] = 32'h0000_0201;
    stream_exp[3] = 32'h0000_0302;
    stream_exp[4] = 32'h0000_0403;

    #1;
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_zero", 32'(rsp_zero), 32'd0);
    chk("reset_illegal", 32'(rsp_illegal), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1);
    run_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 0, 1);

    run_op("sra4", 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 5);
    run_op("srl4", 4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 5);
    run_op("sll31", 4'd6, 32'h1, 32'd31, 32'h8000_0000, 0, 32);

    run_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1);
    run_op("slt_pos", 4'd5, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 1);
    run_op("sll32", 4'd6, 32'h0000_1234, 32'h20, 32'h0000_1234, 0, 1);

    // backpressure: held XOR, then AND accepted in the same cycle
    rsp_ready = 1'b0;
    drive(4'd4, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("xor_result", rsp_result, 32'h0000_0FF0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("xor_held", rsp_result, 32'h0000_0FF0);
      chk("xor_hold_ready", 32'(req_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    drive(4'd2, 32'h0000_F0F0, 32'h0000_FF00);
    @(negedge clk);
    chk("and_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      drive(4'd0, 32'(i + 1) << 8, 32'(i));
      @(negedge clk);
      chk("stream_valid", 32'(rsp_valid), 32'd1);
      chk("stream_result", rsp_result, stream_exp[i]);
    end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", rsp_result, stream_exp[4]);
    step();

    run_op("illegal", 4'hA, 32'h1234, 32'h5678, 32'd0, 1, 1);
    run_op("after_ill", 4'd0, 32'd2, 32'd3, 32'd5, 0, 1);

    // flush a long shift midway
    drive(4'd6, 32'h1, 32'd10);
    step();
    req_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("flush_no_rsp", 32'(seen), 32'd0);
    step();

    // asynchronous reset mid-shift
    drive(4'd6, 32'h1, 32'd10);
    step();
    req_valid = 1'b0;
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_result", rsp_result, 32'd0);
    chk("arst_illegal", 32'(rsp_illegal), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst", 4'd0, 32'd3, 32'd4, 32'd7, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
